// File: rtl/fan_speed_ctrl.sv
// fan_speed_ctrl: turns three raw push-buttons into a fan speed level
// (0 = off, 1..4) and a PWM drive whose duty follows that level.
//
// Each button goes through a 2-flop synchronizer and a debouncer, and then
// yields a single-cycle press pulse. The pulses drive the speed FSM.
//
// Ports:
//   i_clk, i_reset_n   clock; asynchronous active-low reset
//   i_btnUp            raw button, raise speed (saturates at 4)
//   i_btnDown          raw button, lower speed (saturates at 0)
//   i_btnOff           raw button, force off (wins over up/down)
//   o_fanState[2:0]    registered speed level, 0..4
//   o_fanPwm           registered PWM, duty = level/4 of PWM_PERIOD
//   o_autoOffArmed     high while the idle auto-off timer is running
//
// Optional feature, macro FAN_AUTO_OFF_EN: if no press pulse arrives for
// AUTO_OFF_TICKS clocks while the fan is on, the state drops to OFF.
// Without the macro there is no idle timer and o_autoOffArmed is held at 0.

// Per-button front end: synchronizer, debouncer and rising-edge pulse.
module fan_btn_debounce #(
    parameter int CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          sync_a, sync_b;
    logic          level, level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            level_d <= level;
            // The pulse is registered, so the FSM sees it one clock after
            // the debounced level rises. Releasing the button gives no pulse.
            pulse   <= level & ~level_d;
            // Any agreeing sample restarts the count. A level change therefore
            // needs CYCLES consecutive disagreeing samples.
            if (sync_b != level) begin
                if (cnt == CW'(CYCLES - 1)) begin
                    level <= sync_b;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module fan_speed_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int PWM_PERIOD      = 1000,
    parameter int AUTO_OFF_TICKS  = 500000000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_btnUp,
    input  logic       i_btnDown,
    input  logic       i_btnOff,
    output logic [2:0] o_fanState,
    output logic       o_fanPwm,
    output logic       o_autoOffArmed
);
    localparam int PWM_W   = $clog2(PWM_PERIOD + 1);
    localparam int QUARTER = PWM_PERIOD / 4;

    typedef enum logic [2:0] {
        OFF = 3'd0,
        L1  = 3'd1,
        L2  = 3'd2,
        L3  = 3'd3,
        L4  = 3'd4
    } state_t;

    // Bit order of the button vectors: 0 = up, 1 = down, 2 = off.
    logic [2:0] raw, pulse;
    logic       up, down, off, any_press;
    state_t     state, state_nxt;

    assign raw = {i_btnOff, i_btnDown, i_btnUp};

    for (genvar b = 0; b < 3; b++) begin : g_btn
        fan_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (i_clk),
            .rst_n (i_reset_n),
            .raw   (raw[b]),
            .pulse (pulse[b])
        );
    end

    assign up        = pulse[0];
    assign down      = pulse[1];
    assign off       = pulse[2];
    assign any_press = |pulse;

`ifdef FAN_AUTO_OFF_EN
    localparam int IDLE_W = (AUTO_OFF_TICKS > 1) ? $clog2(AUTO_OFF_TICKS) : 1;

    logic [IDLE_W-1:0] idle;
    logic              idle_expired;

    assign idle_expired = (idle == IDLE_W'(AUTO_OFF_TICKS - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                       idle <= '0;
        else if (any_press || state == OFF)   idle <= '0;
        else                                  idle <= idle + 1'b1;
    end
`else
    logic unused_auto_off;
    assign unused_auto_off = (AUTO_OFF_TICKS != 0);
`endif

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= OFF;
        else            state <= state_nxt;
    end

    // FSM next state. A simultaneous up and down press cancels out, but it
    // still counts as activity for the idle timer.
    always_comb begin
        state_nxt = state;
        if (state > L4) begin
            state_nxt = OFF;
        end else if (off) begin
            state_nxt = OFF;
        end else if (up && !down) begin
            case (state)
                OFF:     state_nxt = L1;
                L1:      state_nxt = L2;
                L2:      state_nxt = L3;
                default: state_nxt = L4;
            endcase
        end else if (down && !up) begin
            case (state)
                L4:      state_nxt = L3;
                L3:      state_nxt = L2;
                L2:      state_nxt = L1;
                default: state_nxt = OFF;
            endcase
        end
`ifdef FAN_AUTO_OFF_EN
        else if (!any_press && idle_expired && state != OFF) begin
            state_nxt = OFF;
        end
`endif
    end

    // FSM outputs
    always_comb begin
        o_fanState = state;
`ifdef FAN_AUTO_OFF_EN
        o_autoOffArmed = (state != OFF);
`else
        o_autoOffArmed = 1'b0;
`endif
    end

    // PWM. The counter runs freely and is never restarted on a level change,
    // so a new duty applies from the next compare.
    logic [PWM_W-1:0] pwm_cnt, duty;

    always_comb begin
        case (state)
            L1:      duty = PWM_W'(QUARTER);
            L2:      duty = PWM_W'(2 * QUARTER);
            L3:      duty = PWM_W'(3 * QUARTER);
            L4:      duty = PWM_W'(PWM_PERIOD);
            default: duty = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pwm_cnt  <= '0;
            o_fanPwm <= 1'b0;
        end else begin
            pwm_cnt  <= (pwm_cnt == PWM_W'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + 1'b1;
            o_fanPwm <= (pwm_cnt < duty);
        end
    end
endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Testbench for fan_speed_ctrl. It uses a table of press vectors,
// hand-written corner sequences and random button bursts. Every cycle the
// outputs are compared against a behavioural model. In that model a button
// counts as pressed once its 2-cycle-delayed input has disagreed with the
// accepted level for D consecutive samples.
module tb_fan_speed_ctrl;
    localparam int D = 4;
    localparam int P = 8;
    localparam int A = 50;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       up = 1'b0, dn = 1'b0, off = 1'b0;
    logic [2:0] fan_state;
    logic       fan_pwm, armed;

    always #5 clk = ~clk;

    fan_speed_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .PWM_PERIOD      (P),
        .AUTO_OFF_TICKS  (A)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_btnUp        (up),
        .i_btnDown      (dn),
        .i_btnOff       (off),
        .o_fanState     (fan_state),
        .o_fanPwm       (fan_pwm),
        .o_autoOffArmed (armed)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0] rawq[$];   // raw buttons {off,down,up} applied before each edge
    logic [2:0] lvlq[$];   // accepted button levels after each edge
    int         m_run[3];
    int         m_state, m_idle, m_edge;
    logic       m_pwm;

    function automatic logic [2:0] lvl_at(input int k);
        if (k < 0) return 3'b000;
        return lvlq[k];
    endfunction

    function automatic logic exp_armed();
`ifdef FAN_AUTO_OFF_EN
        return (m_state != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        rawq.delete();
        lvlq.delete();
        for (int b = 0; b < 3; b++) m_run[b] = 0;
        m_state = 0;
        m_idle  = 0;
        m_edge  = 0;
        m_pwm   = 1'b0;
    endtask

    task automatic model_edge(input logic u, input logic d, input logic o);
        logic [2:0] r, samp, prev, nl, p;
        int         ns;
        r = {o, d, u};
        rawq.push_back(r);
        samp = (m_edge >= 2) ? rawq[m_edge-2] : 3'b000;
        prev = lvl_at(m_edge - 1);
        nl   = prev;
        for (int b = 0; b < 3; b++) begin
            if (samp[b] != prev[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    nl[b]    = samp[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        lvlq.push_back(nl);
        // A level that rose after edge k-2 is seen by the FSM at edge k.
        p = lvl_at(m_edge - 2) & ~lvl_at(m_edge - 3);
        m_pwm = ((m_edge % P) < (m_state * P / 4));
        ns = m_state;
        if (p[2])              ns = 0;
        else if (p[0] && !p[1]) ns = (m_state >= 4) ? 4 : m_state + 1;
        else if (p[1] && !p[0]) ns = (m_state <= 0) ? 0 : m_state - 1;
`ifdef FAN_AUTO_OFF_EN
        else if (p == 3'b000 && m_state != 0 && m_idle == A - 1) ns = 0;
        m_idle = (p != 3'b000 || m_state == 0) ? 0 : m_idle + 1;
`endif
        m_state = ns;
        m_edge++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic u, input logic d, input logic o);
        up = u; dn = d; off = o;
        @(posedge clk);
        model_edge(u, d, o);
        #1;
        check("state_vs_model", fan_state, m_state);
        check("pwm_vs_model", fan_pwm, m_pwm);
        check("armed_vs_model", armed, exp_armed());
    endtask

    task automatic press(input logic u, input logic d, input logic o, input int hold, input int gap);
        repeat (hold) step(u, d, o);
        repeat (gap) step(1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset asynchronously mid-cycle and check the outputs clear with no clock edge.
    task automatic do_reset(input logic hold_up);
        up = hold_up; dn = 1'b0; off = 1'b0;
        rst_n = 1'b0;
        #2;
        check("reset_state", fan_state, 0);
        check("reset_pwm", fan_pwm, 0);
        check("reset_armed", armed, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic reach_l3();
        int n;
        do_reset(1'b0);
        press(1'b1, 1'b0, 1'b0, 10, 10);
        press(1'b1, 1'b0, 1'b0, 10, 10);
        n = 0;
        while (fan_state != 3'd3 && n < 20) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("reach_l3", fan_state, 3);
    endtask

    typedef struct {
        logic       u, d, o;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cnt, t, t2;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd2};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd3};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd4};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd4};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'd3};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'd2};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 3'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd2};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 3'd2};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 3'd0};

        model_reset();
        do_reset(1'b0);

        // First press: the state changes exactly 8 edges after the press starts.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 7) check("latency_before", fan_state, 0);
            if (i == 8) check("latency_at", fan_state, 1);
        end
        press(1'b1, 1'b0, 1'b0, 2, 10);

        for (int i = 0; i < 12; i++) begin
            press(tbl[i].u, tbl[i].d, tbl[i].o, 10, 10);
            check($sformatf("table_%0d", i), fan_state, tbl[i].exp);
        end

        // Glitch and bounce on up give nothing; a stable press gives one step up.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("glitch_hold", fan_state, 0);
        end
        repeat (6) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step((i % 2) == 0, 1'b0, 1'b0);
            check("bounce_hold", fan_state, 0);
        end
        press(1'b1, 1'b0, 1'b0, 10, 0);
        check("bounce_then_stable", fan_state, 1);
        press(1'b0, 1'b0, 1'b0, 10, 0);
        check("release_no_change", fan_state, 1);

        // PWM duty at each level, then async reset while at L4 (PWM high).
        do_reset(1'b0);
        for (int lv = 1; lv <= 4; lv++) begin
            press(1'b1, 1'b0, 1'b0, 10, 10);
            cnt = 0;
            repeat (8) begin
                step(1'b0, 1'b0, 1'b0);
                cnt += int'(fan_pwm);
            end
            check($sformatf("pwm_duty_L%0d", lv), cnt, 2 * lv);
        end
        check("pwm_high_before_reset", fan_pwm, 1);
        do_reset(1'b0);
        cnt = 0;
        repeat (8) begin
            step(1'b0, 1'b0, 1'b0);
            cnt += int'(fan_pwm);
        end
        check("pwm_duty_off", cnt, 0);

        // Reset while up is held: after release the held button counts as a new press.
        press(1'b1, 1'b0, 1'b0, 15, 0);
        check("pre_reset_press", fan_state, 1);
        do_reset(1'b1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 7) check("held_after_reset_before", fan_state, 0);
            if (i == 8) check("held_after_reset_at", fan_state, 1);
        end
        press(1'b0, 1'b0, 1'b0, 10, 0);

`ifdef FAN_AUTO_OFF_EN
        reach_l3();
        check("armed_at_l3", armed, 1);
        t = 0;
        while (fan_state == 3'd3 && t < 100) begin
            step(1'b0, 1'b0, 1'b0);
            t++;
        end
        check("auto_off_delay", t, A);
        check("auto_off_state", fan_state, 0);

        // A down press at clock 40 lands before the timeout, so the count restarts.
        reach_l3();
        repeat (39) step(1'b0, 1'b0, 1'b0);
        t = 39;
        t2 = -1;
        for (int i = 0; i < 80 && fan_state != 3'd0; i++) begin
            step(1'b0, i < 10, 1'b0);
            t++;
            if (fan_state == 3'd2 && t2 < 0) t2 = t;
        end
        check("restart_press_edge", t2, 47);
        check("restart_auto_off_delay", t - t2, A);
        check("restart_auto_off_state", fan_state, 0);
`else
        reach_l3();
        repeat (200) step(1'b0, 1'b0, 1'b0);
        check("no_auto_off_state", fan_state, 3);
        check("no_auto_off_armed", armed, 0);
`endif

        // Random bursts checked against the model every cycle.
        do_reset(1'b0);
        for (int i = 0; i < 150; i++) begin
            logic ru, rd, ro;
            int   hold;
            ru   = ($urandom_range(0, 9) < 4);
            rd   = ($urandom_range(0, 9) < 3);
            ro   = ($urandom_range(0, 15) == 0);
            hold = $urandom_range(1, 12);
            repeat (hold) step(ru, rd, ro);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
